// File: rtl/fp_normalize_pack.sv
`default_nettype none
// ============================================================================
// Module   : fp_normalize_pack
// Purpose  : Floating-point ALU back end. Takes a raw sign, extended exponent
//            and unnormalised mantissa from the add/multiply datapath. It
//            normalises one bit per cycle, rounds to nearest-even, and packs
//            the value into an IEEE-754 word. The word is then delivered over
//            a valid/ready handshake.
// Revision : 1.0 - initial release
//
// Ports:
//   clk            clock
//   reset          asynchronous, active-low reset
//   in_valid       operand valid
//   in_ready       block can accept operand (high only when idle)
//   in_sign        result sign
//   in_exponent    [EXP_W:0] biased exponent, MSB = upstream overflow
//   in_mantissa    [FRAC_W+3:0] {carry, hidden, frac, guard, sticky}
//   out_valid      result valid
//   out_ready      consumer accepts result
//   result         [EXP_W+FRAC_W:0] packed {sign, exp, frac}
//   flag_overflow  result saturated to infinity
//   flag_underflow result denormal or flushed
//   flag_zero      result is +/-0
//   flag_inexact   guard or sticky nonzero at rounding
//
// Build option:
//   FP_FTZ_EN      when defined, denormal results are flushed to signed zero
// ============================================================================
module fp_normalize_pack #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int BIAS   = 127
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic [EXP_W:0]          in_exponent,
  input  logic [FRAC_W+3:0]       in_mantissa,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W:0]   result,
  output logic                    flag_overflow,
  output logic                    flag_underflow,
  output logic                    flag_zero,
  output logic                    flag_inexact
);

  localparam int                MANT_W    = FRAC_W + 4;
  localparam int                CARRY_BIT = FRAC_W + 3;
  localparam int                HIDDEN_BIT = FRAC_W + 2;
  localparam logic [EXP_W:0]    EXP_ONE   = (EXP_W+1)'(1);
  localparam logic [EXP_W:0]    EXP_LIMIT = (EXP_W+1)'(2*BIAS+1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                  state, state_d;
  logic                    sign_q, sign_d;
  logic [EXP_W:0]          exp_q, exp_d;
  logic [MANT_W-1:0]       mant_q, mant_d;
  logic [EXP_W+FRAC_W:0]   result_d;
  logic                    valid_d, ovf_d, unf_d, zero_d, inx_d;

  // Rounding datapath, evaluated from the registered operand
  logic                    round_up, inexact;
  logic [FRAC_W+1:0]       sig_sum;   // {carry-out, hidden, frac}
  logic [EXP_W:0]          rnd_exp;
  logic [FRAC_W-1:0]       rnd_frac;

  assign in_ready = (state == IDLE);

  always_comb begin
    inexact  = mant_q[1] | mant_q[0];
    round_up = mant_q[1] & (mant_q[0] | mant_q[2]);
    sig_sum  = {1'b0, mant_q[HIDDEN_BIT:2]} + {{(FRAC_W+1){1'b0}}, round_up};
    rnd_exp  = exp_q;
    rnd_frac = sig_sum[FRAC_W-1:0];
    if (sig_sum[FRAC_W+1]) begin
      rnd_frac = '0;
      rnd_exp  = exp_q + EXP_ONE;
    end else if ((exp_q == '0) && sig_sum[FRAC_W]) begin
      // A denormal rounded up into the normal range
      rnd_exp = EXP_ONE;
    end
  end

  always_comb begin
    state_d  = state;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mant_d   = mant_q;
    result_d = result;
    valid_d  = out_valid;
    ovf_d    = flag_overflow;
    unf_d    = flag_underflow;
    zero_d   = flag_zero;
    inx_d    = flag_inexact;

    case (state)
      IDLE: begin
        if (in_valid) begin
          sign_d = in_sign;
          exp_d  = in_exponent;
          mant_d = in_mantissa;
          if (in_exponent[EXP_W]) begin
            state_d  = DONE;
            valid_d  = 1'b1;
            ovf_d    = 1'b1;
            result_d = {in_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          end else begin
            state_d = SHIFT;
          end
        end
      end

      SHIFT: begin
        if (mant_q == '0) begin
          state_d  = DONE;
          valid_d  = 1'b1;
          zero_d   = 1'b1;
          result_d = {sign_q, {(EXP_W+FRAC_W){1'b0}}};
        end else if (mant_q[CARRY_BIT]) begin
          // Right shift folds the bit leaving the guard slot into sticky
          mant_d  = {1'b0, mant_q[MANT_W-1:2], mant_q[1] | mant_q[0]};
          exp_d   = exp_q + EXP_ONE;
          state_d = ROUND;
        end else if (mant_q[HIDDEN_BIT]) begin
          state_d = ROUND;
        end else if (exp_q <= EXP_ONE) begin
          exp_d   = '0;
          state_d = ROUND;
        end else begin
          mant_d = mant_q << 1;
          exp_d  = exp_q - EXP_ONE;
        end
      end

      ROUND: begin
        state_d = DONE;
        valid_d = 1'b1;
        inx_d   = inexact;
        if (rnd_exp >= EXP_LIMIT) begin
          ovf_d    = 1'b1;
          inx_d    = 1'b1;
          result_d = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else if (rnd_exp == '0) begin
          if (rnd_frac != '0) begin
`ifdef FP_FTZ_EN
            zero_d   = 1'b1;
            unf_d    = 1'b1;
            result_d = {sign_q, {(EXP_W+FRAC_W){1'b0}}};
`else
            unf_d    = inexact;
            result_d = {sign_q, {EXP_W{1'b0}}, rnd_frac};
`endif
          end else begin
            // Only guard/sticky bits survived: the value rounded to zero
            zero_d   = 1'b1;
            result_d = {sign_q, {(EXP_W+FRAC_W){1'b0}}};
          end
        end else begin
          result_d = {sign_q, rnd_exp[EXP_W-1:0], rnd_frac};
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          zero_d  = 1'b0;
          inx_d   = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sign_q         <= 1'b0;
      exp_q          <= '0;
      mant_q         <= '0;
      result         <= '0;
      out_valid      <= 1'b0;
      flag_overflow  <= 1'b0;
      flag_underflow <= 1'b0;
      flag_zero      <= 1'b0;
      flag_inexact   <= 1'b0;
    end else begin
      sign_q         <= sign_d;
      exp_q          <= exp_d;
      mant_q         <= mant_d;
      result         <= result_d;
      out_valid      <= valid_d;
      flag_overflow  <= ovf_d;
      flag_underflow <= unf_d;
      flag_zero      <= zero_d;
      flag_inexact   <= inx_d;
    end
  end

endmodule
`default_nettype wire
